rts_signature_checker: RTL and testbench

Signature checker downstream of the Random Test Socket BIST datapath. It captures the MISR and SISA signatures when the RTS controller raises `done` and either learns them as the golden pair or compares them against it. It flags a mismatch per session and keeps saturating session and detected-fault counters. This moves the golden-compare and coverage bookkeeping out of the bench and into hardware.

---
 rtl/rts_signature_checker.sv | 153 +++++++++++++++
 tb/tb_rts_signature_checker.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rts_signature_checker.sv
// Captures MISR/SISA signatures on the rising edge of done, then learns them as golden or compares against golden.
// Result one cycle after capture; no backpressure: start/golden_we outside IDLE are dropped.
module rts_signature_checker #(
    parameter int MISR_Size = 24,
    parameter int SISA_Size = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 learn,
    input  logic                 done,
    input  logic [MISR_Size-1:0] misr_sig,
    input  logic [SISA_Size-1:0] sisa_sig,
    input  logic                 golden_we,
    input  logic [MISR_Size-1:0] golden_misr_in,
    input  logic [SISA_Size-1:0] golden_sisa_in,
    input  logic                 clr_cnt,
    output logic                 busy,
    output logic                 result_valid,
    output logic                 mismatch,
    output logic                 no_golden,
    output logic                 golden_valid,
    output logic [CNT_W-1:0]     session_cnt,
    output logic [CNT_W-1:0]     detect_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_COMPARE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state, state_nx;

    logic                 done_q;
    logic                 rise;
    logic                 mode;
    logic [MISR_Size-1:0] cap_misr;
    logic [SISA_Size-1:0] cap_sisa;
    logic [MISR_Size-1:0] gold_misr;
    logic [SISA_Size-1:0] gold_sisa;

    logic in_idle;
    logic in_compare;
    logic capture;
    logic gold_load;
    logic sig_diff;
    logic cmp_mismatch;
    logic inc_session;
    logic inc_detect;

    assign rise       = done & ~done_q;
    assign in_idle    = (state == S_IDLE);
    assign in_compare = (state == S_COMPARE);
    assign capture    = (state == S_ARMED) && rise;
    assign gold_load  = in_idle && golden_we;
    assign busy       = !in_idle;

    assign sig_diff     = ({cap_misr, cap_sisa} != {gold_misr, gold_sisa});
    // Comparing against nothing is reported as a detected fault.
    assign cmp_mismatch = golden_valid ? sig_diff : 1'b1;
    assign inc_session  = in_compare && !mode;
    assign inc_detect   = inc_session && cmp_mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start) state_nx = S_ARMED;
            S_ARMED:   if (rise)  state_nx = S_COMPARE;
            S_COMPARE: state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // done_q runs in every state so a done already high at arm time never looks like a rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q   <= 1'b0;
            mode     <= 1'b0;
            cap_misr <= '0;
            cap_sisa <= '0;
        end else begin
            done_q <= done;
            if (in_idle && start) begin
                mode <= learn;
            end
            if (capture) begin
                cap_misr <= misr_sig;
                cap_sisa <= sisa_sig;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gold_misr    <= '0;
            gold_sisa    <= '0;
            golden_valid <= 1'b0;
        end else if (gold_load) begin
            gold_misr    <= golden_misr_in;
            gold_sisa    <= golden_sisa_in;
            golden_valid <= 1'b1;
        end else if (in_compare && mode) begin
            gold_misr    <= cap_misr;
            gold_sisa    <= cap_sisa;
            golden_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_valid <= 1'b0;
            mismatch     <= 1'b0;
            no_golden    <= 1'b0;
        end else begin
            result_valid <= in_compare;
            if (in_compare) begin
                mismatch  <= mode ? 1'b0 : cmp_mismatch;
                no_golden <= !mode && !golden_valid;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            session_cnt <= '0;
            detect_cnt  <= '0;
        end else if (clr_cnt) begin
            session_cnt <= '0;
            detect_cnt  <= '0;
        end else begin
            if (inc_session && session_cnt != CNT_MAX) begin
                session_cnt <= session_cnt + CNT_ONE;
            end
            if (inc_detect && detect_cnt != CNT_MAX) begin
                detect_cnt <= detect_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_rts_signature_checker.sv
// Randomized bench for rts_signature_checker against a session-level reference model.
module tb_rts_signature_checker;

    localparam int MW   = 24;
    localparam int SW   = 16;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, learn, done, golden_we, clr_cnt;
    logic [MW-1:0] misr_sig, golden_misr_in;
    logic [SW-1:0] sisa_sig, golden_sisa_in;
    logic          busy, result_valid, mismatch, no_golden, golden_valid;
    logic [CW-1:0] session_cnt, detect_cnt;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    bit            m_gv;
    logic [MW-1:0] m_gm;
    logic [SW-1:0] m_gs;
    bit            m_mis, m_ng;
    int            m_sess, m_det;

    rts_signature_checker #(.MISR_Size(MW), .SISA_Size(SW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .learn(learn), .done(done),
        .misr_sig(misr_sig), .sisa_sig(sisa_sig), .golden_we(golden_we),
        .golden_misr_in(golden_misr_in), .golden_sisa_in(golden_sisa_in),
        .clr_cnt(clr_cnt), .busy(busy), .result_valid(result_valid),
        .mismatch(mismatch), .no_golden(no_golden), .golden_valid(golden_valid),
        .session_cnt(session_cnt), .detect_cnt(detect_cnt)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_gv = 0; m_gm = '0; m_gs = '0; m_mis = 0; m_ng = 0; m_sess = 0; m_det = 0;
    endfunction

    function automatic void model_session(input bit l, input logic [MW-1:0] m,
                                          input logic [SW-1:0] s, input bit clr);
        if (l) begin
            m_gm = m; m_gs = s; m_gv = 1; m_mis = 0; m_ng = 0;
        end else begin
            m_ng  = !m_gv;
            m_mis = !m_gv || (m != m_gm) || (s != m_gs);
            if (m_sess < CMAX) m_sess++;
            if (m_mis && m_det < CMAX) m_det++;
        end
        if (clr) begin
            m_sess = 0; m_det = 0;
        end
    endfunction

    // Drives one full session; got reports whether result_valid appeared exactly one cycle after capture.
    task automatic do_session(input bit l, input logic [MW-1:0] m, input logic [SW-1:0] s,
                              input bit clr, output bit got);
        @(posedge clk); #1 done = 0; start = 1; learn = l;
        @(posedge clk); #1 start = 0; misr_sig = m; sisa_sig = s; done = 1;
        @(posedge clk); #1 misr_sig = MW'($urandom); sisa_sig = SW'($urandom); clr_cnt = clr;
        @(posedge clk); #1 clr_cnt = 0;
        @(negedge clk) got = result_valid;
        model_session(l, m, s, clr);
    endtask

    task automatic load_golden(input logic [MW-1:0] m, input logic [SW-1:0] s);
        @(posedge clk); #1 golden_we = 1; golden_misr_in = m; golden_sisa_in = s;
        @(posedge clk); #1 golden_we = 0;
        m_gm = m; m_gs = s; m_gv = 1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1; done = 0;
        @(posedge clk); #1 rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({busy, result_valid, mismatch, no_golden, golden_valid, session_cnt, detect_cnt} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {busy, result_valid, mismatch, no_golden, golden_valid, session_cnt, detect_cnt});
        end
        @(posedge clk); #1 rst = 0;
        model_reset();
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || golden_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: busy=%b golden_valid=%b expected 0 0", busy, golden_valid);
        end
    endtask

    task automatic test_learn();
        bit got;
        do_session(1'b1, 24'h00ABCD, 16'h1234, 1'b0, got);
        vectors++;
        if (got !== 1'b1 || mismatch !== 1'b0 || golden_valid !== 1'b1 || session_cnt !== 2'd0) begin
            miscompares++;
            $display("FAIL learn: got rv=%b mis=%b gv=%b sess=%0d expected 1 0 1 0",
                     got, mismatch, golden_valid, session_cnt);
        end
        @(negedge clk);
        vectors++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL learn_pulse_width: rv=%b busy=%b expected 0 0", result_valid, busy);
        end
    endtask

    task automatic test_compare();
        bit got;
        do_session(1'b0, 24'h00ABCD, 16'h1234, 1'b0, got);
        vectors++;
        if (got !== 1'b1 || mismatch !== 1'b0 || session_cnt !== 2'd1 || detect_cnt !== 2'd0) begin
            miscompares++;
            $display("FAIL compare_pass: rv=%b mis=%b sess=%0d det=%0d expected 1 0 1 0",
                     got, mismatch, session_cnt, detect_cnt);
        end
        do_session(1'b0, 24'h00ABCD, 16'h1235, 1'b0, got);
        vectors++;
        if (got !== 1'b1 || mismatch !== 1'b1 || no_golden !== 1'b0 ||
            session_cnt !== 2'd2 || detect_cnt !== 2'd1) begin
            miscompares++;
            $display("FAIL compare_fail: rv=%b mis=%b ng=%b sess=%0d det=%0d expected 1 1 0 2 1",
                     got, mismatch, no_golden, session_cnt, detect_cnt);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (mismatch !== 1'b1) begin
            miscompares++;
            $display("FAIL mismatch_hold: got %b expected 1", mismatch);
        end
    endtask

    task automatic test_done_held();
        bit seen = 0;
        bit busy_ok = 1;
        @(posedge clk); #1 done = 1;
        @(posedge clk); #1 start = 1; learn = 0;
        @(posedge clk); #1 start = 0; golden_we = 1;
        golden_misr_in = ~m_gm; golden_sisa_in = ~m_gs;
        @(posedge clk); #1 golden_we = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (result_valid) seen = 1;
            if (!busy) busy_ok = 0;
        end
        vectors++;
        if (seen || !busy_ok) begin
            miscompares++;
            $display("FAIL done_held: result_seen=%b busy_held=%b expected 0 1", seen, busy_ok);
        end
        @(posedge clk); #1 done = 0;
        @(posedge clk); #1 done = 1; misr_sig = m_gm; sisa_sig = m_gs;
        @(posedge clk); #1 misr_sig = ~m_gm;
        @(posedge clk);
        @(negedge clk);
        model_session(1'b0, m_gm, m_gs, 1'b0);
        vectors++;
        if (result_valid !== 1'b1 || mismatch !== 1'b0 || session_cnt !== 2'(m_sess)) begin
            miscompares++;
            $display("FAIL armed_golden_we_ignored: rv=%b mis=%b sess=%0d expected 1 0 %0d",
                     result_valid, mismatch, session_cnt, m_sess);
        end
    endtask

    task automatic test_saturation_clear();
        bit got;
        for (int i = 0; i < 5; i++) begin
            do_session(1'b0, ~m_gm, m_gs, 1'b0, got);
            vectors++;
            if (got !== 1'b1 || mismatch !== 1'b1 || session_cnt !== 2'(m_sess) || detect_cnt !== 2'(m_det)) begin
                miscompares++;
                $display("FAIL saturate_%0d: rv=%b mis=%b sess=%0d det=%0d expected 1 1 %0d %0d",
                         i, got, mismatch, session_cnt, detect_cnt, m_sess, m_det);
            end
        end
        vectors++;
        if (session_cnt !== 2'd3 || detect_cnt !== 2'd3) begin
            miscompares++;
            $display("FAIL saturate_hold: sess=%0d det=%0d expected 3 3", session_cnt, detect_cnt);
        end
        do_session(1'b0, ~m_gm, m_gs, 1'b1, got);
        vectors++;
        if (got !== 1'b1 || session_cnt !== 2'd0 || detect_cnt !== 2'd0) begin
            miscompares++;
            $display("FAIL clr_wins: rv=%b sess=%0d det=%0d expected 1 0 0", got, session_cnt, detect_cnt);
        end
    endtask

    task automatic test_no_golden();
        bit got;
        pulse_reset();
        do_session(1'b0, MW'($urandom), SW'($urandom), 1'b0, got);
        vectors++;
        if (got !== 1'b1 || mismatch !== 1'b1 || no_golden !== 1'b1 ||
            session_cnt !== 2'd1 || detect_cnt !== 2'd1) begin
            miscompares++;
            $display("FAIL no_golden: rv=%b mis=%b ng=%b sess=%0d det=%0d expected 1 1 1 1 1",
                     got, mismatch, no_golden, session_cnt, detect_cnt);
        end
    endtask

    task automatic test_reset_mid_session();
        bit got;
        bit seen = 0;
        load_golden(24'h123456, 16'hBEEF);
        @(posedge clk); #1 start = 1; learn = 0; done = 0;
        @(posedge clk); #1 start = 0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL armed_busy: got %b expected 1", busy);
        end
        #2 rst = 1; done = 1;
        #1;
        vectors++;
        if ({busy, result_valid, mismatch, no_golden, golden_valid, session_cnt, detect_cnt} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got %b expected all zero",
                     {busy, result_valid, mismatch, no_golden, golden_valid, session_cnt, detect_cnt});
        end
        @(posedge clk); #1 rst = 0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (result_valid) seen = 1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL reset_abort: result_valid seen=%b expected 0", seen);
        end
        do_session(1'b0, 24'h123456, 16'hBEEF, 1'b0, got);
        vectors++;
        if (got !== 1'b1 || no_golden !== 1'b1 || mismatch !== 1'b1 || session_cnt !== 2'd1) begin
            miscompares++;
            $display("FAIL post_reset_session: rv=%b ng=%b mis=%b sess=%0d expected 1 1 1 1",
                     got, no_golden, mismatch, session_cnt);
        end
    endtask

    task automatic test_random();
        bit got, l, clr;
        logic [MW-1:0] m;
        logic [SW-1:0] s;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(3) == 0) load_golden(MW'($urandom), SW'($urandom));
            l   = ($urandom_range(3) == 0);
            clr = ($urandom_range(7) == 0);
            if ($urandom_range(1) == 1) begin
                m = m_gm; s = m_gs;
                if ($urandom_range(2) == 0) s[$urandom_range(SW-1)] ^= 1'b1;
            end else begin
                m = MW'($urandom); s = SW'($urandom);
            end
            do_session(l, m, s, clr, got);
            vectors++;
            if (got !== 1'b1 || mismatch !== m_mis || no_golden !== m_ng || golden_valid !== m_gv ||
                session_cnt !== 2'(m_sess) || detect_cnt !== 2'(m_det)) begin
                miscompares++;
                $display("FAIL random_%0d: rv=%b mis=%b ng=%b gv=%b sess=%0d det=%0d expected 1 %b %b %b %0d %0d",
                         i, got, mismatch, no_golden, golden_valid, session_cnt, detect_cnt,
                         m_mis, m_ng, m_gv, m_sess, m_det);
            end
        end
    endtask

    initial begin
        rst = 1; start = 0; learn = 0; done = 0; golden_we = 0; clr_cnt = 0;
        misr_sig = '0; sisa_sig = '0; golden_misr_in = '0; golden_sisa_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        test_reset();
        test_learn();
        test_compare();
        test_done_held();
        test_saturation_clear();
        test_no_golden();
        test_reset_mid_session();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
